// File: rtl/conv3x3_accum_ctrl.sv
// Channel-accumulating sequencer around an external 9-tap int8 inner-dot unit:
// accumulates dot results over cfg_cin windows on top of a bias, then requantizes to int8.
module conv3x3_accum_ctrl #(
  parameter int SUM_WIDTH = 20,
  parameter int ACC_WIDTH = 26,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_cin,
  input  logic [3:0]           cfg_shift,
  input  logic                 cfg_relu,
  input  logic [15:0]          bias,
  input  logic                 win_valid,
  output logic                 win_ready,
  input  logic [71:0]          win_data,
  input  logic [71:0]          win_weight,
  output logic [71:0]          dot_data,
  output logic [71:0]          dot_weight,
  input  logic [SUM_WIDTH-1:0] dot_ans,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_QUANT,
    S_OUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0]        CNT_ONE = CNT_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -ACC_WIDTH'(128);

  state_t                       r_state;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [CNT_WIDTH-1:0]         r_ch_cnt;
  logic [CNT_WIDTH-1:0]         r_cin;
  logic [3:0]                   r_shift;
  logic                         r_relu;
  logic [7:0]                   r_out_data;
  logic                         r_out_valid;
  logic                         r_busy;
  logic                         r_done;

  logic                         w_accum;
  logic signed [ACC_WIDTH-1:0]  w_dot_ext;
  logic signed [ACC_WIDTH-1:0]  w_bias_ext;
  logic signed [ACC_WIDTH-1:0]  w_shifted;
  logic signed [ACC_WIDTH-1:0]  w_relu_val;
  logic [7:0]                   w_quant;

  assign w_accum    = (r_state == S_ACCUM);
  assign win_ready  = w_accum;
  assign dot_data   = w_accum ? win_data   : 72'd0;
  assign dot_weight = w_accum ? win_weight : 72'd0;

  assign w_dot_ext  = {{(ACC_WIDTH-SUM_WIDTH){dot_ans[SUM_WIDTH-1]}}, dot_ans};
  assign w_bias_ext = {{(ACC_WIDTH-16){bias[15]}}, bias};

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;

  // Requantize: arithmetic shift, optional ReLU, then clamp into int8.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_quant    = 8'd0;
    w_shifted  = r_acc >>> r_shift;
    w_relu_val = (r_relu && w_shifted[ACC_WIDTH-1]) ? '0 : w_shifted;
    if (w_relu_val > SAT_MAX) begin
      w_quant = 8'h7F;
    end else if (w_relu_val < SAT_MIN) begin
      w_quant = 8'h80;
    end else begin
      w_quant = w_relu_val[7:0];
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_ch_cnt    <= '0;
      r_cin       <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The done cycle still belongs to the finishing job, so a start there is dropped.
          if (start && !r_done) begin
            r_cin    <= cfg_cin;
            r_shift  <= cfg_shift;
            r_relu   <= cfg_relu;
            r_acc    <= w_bias_ext;
            r_ch_cnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= (cfg_cin != '0) ? S_ACCUM : S_QUANT;
          end
        end
        S_ACCUM: begin
          if (win_valid) begin
            r_acc    <= r_acc + w_dot_ext;
            r_ch_cnt <= r_ch_cnt + CNT_ONE;
            if (r_ch_cnt == r_cin - CNT_ONE) begin
              r_state <= S_QUANT;
            end
          end
        end
        S_QUANT: begin
          r_out_data  <= w_quant;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_accum_ctrl.sv
// Directed bench for conv3x3_accum_ctrl: driver issues jobs and queues expected pixels,
// an independent monitor pops and compares on every output handshake.
module tb_conv3x3_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  cfg_cin;
  logic [3:0]  cfg_shift;
  logic        cfg_relu;
  logic [15:0] bias;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_data;
  logic [71:0] win_weight;
  logic [71:0] dot_data;
  logic [71:0] dot_weight;
  logic [19:0] dot_ans;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [71:0] wd[8];
  logic [71:0] ww[8];

  always #5 clk = ~clk;

  conv3x3_accum_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_cin    (cfg_cin),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .bias       (bias),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_weight (win_weight),
    .dot_data   (dot_data),
    .dot_weight (dot_weight),
    .dot_ans    (dot_ans),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural stand-in for the external inner-dot instance.
  always_comb begin
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) begin
      s += $signed(dot_data[8*i +: 8]) * $signed(dot_weight[8*i +: 8]);
    end
    dot_ans = s[19:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] t0(input logic [7:0] v);
    return {64'd0, v};
  endfunction

  function automatic logic [71:0] fill(input logic [7:0] v);
    return {9{v}};
  endfunction

  // Monitor: scoreboard pop on every output handshake, done must follow each one by a cycle.
  initial begin
    logic prev_hs;
    logic [7:0] e;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hs = 1'b0;
      end else begin
        if (done || prev_hs) check("done_pulse", {31'd0, done}, {31'd0, prev_hs});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", {24'd0, out_data}, {24'd0, e});
          end
        end
        prev_hs = out_valid && out_ready;
      end
    end
  end

  // Sends windows wd/ww[0..n-1]; enters and leaves at a negedge / posedge+1 respectively.
  task automatic send_wins(input int n, input bit gap);
    int k;
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        @(negedge clk);
        check("gap_hold_ready", {31'd0, win_ready}, 32'd1);
      end
      win_valid  = 1'b1;
      win_data   = wd[i];
      win_weight = ww[i];
      k = 0;
      while (!win_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!win_ready) check("win_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      win_valid = 1'b0;
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic do_start(input int cin, input logic [3:0] sh, input logic rl, input logic [15:0] b);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_win_ready", {31'd0, win_ready}, 32'd0);
    @(posedge clk);
    #1;
    start     = 1'b1;
    cfg_cin   = cin[4:0];
    cfg_shift = sh;
    cfg_relu  = rl;
    bias      = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    cfg_cin   = 5'h1F;
    cfg_shift = 4'hF;
    cfg_relu  = ~rl;
    bias      = 16'h7FFF;
    @(negedge clk);
    check("start_win_ready", {31'd0, win_ready}, (cin != 0) ? 32'd1 : 32'd0);
    check("start_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_job(input int cin, input logic [3:0] sh, input logic rl, input logic [15:0] b,
                         input bit gap, input int hold, input bit start_in_done, input logic [7:0] exp);
    exp_q.push_back(exp);
    out_ready = (hold == 0);
    do_start(cin, sh, rl, b);
    if (cin > 0) begin
      send_wins(cin, gap);
      @(negedge clk);
    end
    check("lat_plus1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_plus2_valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < hold; k++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", {24'd0, out_data}, {24'd0, exp});
      check("bp_win_ready", {31'd0, win_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      if (k == 1) begin
        start   = 1'b1;
        cfg_cin = 5'd1;
      end
      if (k == 2) start = 1'b0;
      if (k == hold - 1) out_ready = 1'b1;
      @(negedge clk);
    end
    check("hs_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    start     = start_in_done;
    cfg_cin   = 5'd1;
    @(negedge clk);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_win_ready", {31'd0, win_ready}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("idle_after_win_ready", {31'd0, win_ready}, 32'd0);
    check("idle_after_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_cin = '0; cfg_shift = '0; cfg_relu = 1'b0; bias = '0;
    win_valid = 1'b0; win_data = '0; win_weight = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_win_ready", {31'd0, win_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    win_data = fill(8'h11);
    win_weight = fill(8'h22);
    #1;
    check("idle_dot_data", dot_data[31:0], 32'd0);

    // Single channel: 9 * 1 * 2 = 18, out_ready already high.
    wd[0] = fill(8'd1); ww[0] = fill(8'd2);
    run_job(1, 4'd0, 1'b0, 16'd0, 1'b0, 0, 1'b0, 8'd18);

    // Four channels: 100+50-20+30-10 = 150, >>>2 = 37; back-to-back then gapped.
    wd[0] = t0(8'd100); ww[0] = t0(8'd1);
    wd[1] = t0(8'd50);  ww[1] = t0(8'd1);
    wd[2] = t0(8'hEC);  ww[2] = t0(8'd1);
    wd[3] = t0(8'd30);  ww[3] = t0(8'd1);
    run_job(4, 4'd2, 1'b0, 16'hFFF6, 1'b0, 0, 1'b0, 8'd37);
    wd[0] = t0(8'd50);  ww[0] = t0(8'd2);
    wd[1] = t0(8'd25);  ww[1] = t0(8'd2);
    wd[2] = t0(8'hFC);  ww[2] = t0(8'd5);
    wd[3] = t0(8'd15);  ww[3] = t0(8'd2);
    run_job(4, 4'd2, 1'b0, 16'hFFF6, 1'b1, 0, 1'b1, 8'd37);

    // Positive saturation: 4 * 9 * 127 * 127.
    for (int i = 0; i < 4; i++) begin
      wd[i] = fill(8'd127);
      ww[i] = fill(8'd127);
    end
    run_job(4, 4'd0, 1'b0, 16'd0, 1'b0, 0, 1'b0, 8'h7F);

    // Negative saturation with 5 cycles of backpressure, then ReLU.
    wd[0] = fill(8'h80); ww[0] = fill(8'd127);
    run_job(1, 4'd0, 1'b0, 16'd0, 1'b0, 5, 1'b0, 8'h80);
    run_job(1, 4'd0, 1'b1, 16'd0, 1'b0, 0, 1'b0, 8'h00);

    // cin=0: bias only. 300>>>1 saturates; -150>>>2 rounds toward minus infinity.
    run_job(0, 4'd1, 1'b0, 16'd300, 1'b0, 0, 1'b0, 8'h7F);
    run_job(0, 4'd2, 1'b0, 16'hFF6A, 1'b0, 0, 1'b0, 8'hDA);

    // Reset after 2 of 4 windows abandons the job.
    wd[0] = t0(8'd100); ww[0] = t0(8'd1);
    wd[1] = t0(8'd50);  ww[1] = t0(8'd1);
    do_start(4, 4'd0, 1'b0, 16'd7);
    send_wins(2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_win_ready", {31'd0, win_ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_quiet_valid", {31'd0, out_valid}, 32'd0);
      check("abort_quiet_done", {31'd0, done}, 32'd0);
    end
    wd[0] = t0(8'd5); ww[0] = t0(8'd1);
    run_job(1, 4'd0, 1'b0, 16'd0, 1'b0, 0, 1'b0, 8'd5);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
